// File: rtl/coin_pulse_gen_pkg.sv
// Shared definitions for the coin front-end and the downstream drink_status FSM.
package coin_pulse_gen_pkg;

  // Sender FSM encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StGap  = 2'd2
  } send_state_e;

  // Default timing constants.
  localparam int unsigned DefDebCycles = 4;
  localparam int unsigned DefJamCycles = 64;
  localparam int unsigned DefGapCycles = 2;
  localparam int unsigned DefCntW      = 7;

  // Coin denominations in half-unit steps, shared with drink_status.
  localparam int unsigned CoinHalfUnits = 1;
  localparam int unsigned CoinOneUnits  = 2;

endpackage

// File: rtl/coin_debounce.sv
// Per-channel sensor conditioning: 2-flop synchroniser, debounce counter,
// jam counter and debounced rise-edge detection.
module coin_debounce
  import coin_pulse_gen_pkg::*;
#(
  parameter int unsigned DebCycles = DefDebCycles,
  parameter int unsigned JamCycles = DefJamCycles,
  parameter int unsigned CntW      = DefCntW
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic rise_o,
  output logic jam_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CntW-1:0] jam_cnt_q, jam_cnt_d;

  // Debounce: flip the level after DebCycles consecutive differing samples;
  // a sample equal to the current level restarts the count. Jam counter
  // tracks the next level so it clears on the same edge the level falls.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == CntW'(DebCycles - 1)) begin
        level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CntW'(1);
      end
    end
    jam_cnt_d = '0;
    if (level_d) begin
      jam_cnt_d = (jam_cnt_q == CntW'(JamCycles)) ? jam_cnt_q : jam_cnt_q + CntW'(1);
    end
  end

  // Edge and jam indications derived from registered state.
  always_comb begin
    rise_o = level_d & ~level_q;
    jam_o  = (jam_cnt_q == CntW'(JamCycles));
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      jam_cnt_q <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      jam_cnt_q <= jam_cnt_d;
    end
  end

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin front-end: conditions both sensors, latches accepted coins as pending
// flags and serialises them into spaced one-cycle half/one pulses.
module coin_pulse_gen
  import coin_pulse_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DefDebCycles,
  parameter int unsigned JAM_CYCLES = DefJamCycles,
  parameter int unsigned GAP_CYCLES = DefGapCycles, // must be >= 1
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic clk,
  input  logic reset,
  input  logic half_raw,
  input  logic one_raw,
  input  logic accept_en,
  output logic half,
  output logic one,
  output logic reject,
  output logic jam_half,
  output logic jam_one
);

  logic             rise_h, rise_o;
  logic             pend_h_q, pend_h_d, pend_o_q, pend_o_d;
  logic             reject_q, reject_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  send_state_e      state_q, state_d;
  logic             pend_any;

  coin_debounce #(
    .DebCycles (DEB_CYCLES),
    .JamCycles (JAM_CYCLES),
    .CntW      (CNT_W)
  ) u_deb_half (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (half_raw),
    .rise_o (rise_h),
    .jam_o  (jam_half)
  );

  coin_debounce #(
    .DebCycles (DEB_CYCLES),
    .JamCycles (JAM_CYCLES),
    .CntW      (CNT_W)
  ) u_deb_one (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (one_raw),
    .rise_o (rise_o),
    .jam_o  (jam_one)
  );

  assign pend_any = pend_h_q | pend_o_q;
  assign reject   = reject_q;

  // Sender FSM, pending-flag bookkeeping and reject generation.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pend_h_d  = pend_h_q;
    pend_o_d  = pend_o_q;
    half      = 1'b0;
    one       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_any) state_d = StEmit;
      end
      StEmit: begin
        // Half has priority; a flag cleared by a jam leaves this slot empty.
        half      = pend_h_q;
        one       = ~pend_h_q & pend_o_q;
        if (pend_h_q) pend_h_d = 1'b0;
        else          pend_o_d = 1'b0;
        gap_cnt_d = '0;
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          // Skip IDLE so back-to-back coins are spaced by exactly the gap.
          state_d = pend_any ? StEmit : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // New coins win over the emit clear; a jam discards an unsent coin.
    if (rise_h && !jam_half && accept_en) pend_h_d = 1'b1;
    if (rise_o && !jam_one && accept_en)  pend_o_d = 1'b1;
    if (jam_half) pend_h_d = 1'b0;
    if (jam_one)  pend_o_d = 1'b0;

    reject_d = ~accept_en & ((rise_h & ~jam_half) | (rise_o & ~jam_one));
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      pend_h_q  <= 1'b0;
      pend_o_q  <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pend_h_q  <= pend_h_d;
      pend_o_q  <= pend_o_d;
      reject_q  <= reject_d;
    end
  end

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed self-checking bench for coin_pulse_gen with default parameters.
module tb_coin_pulse_gen;

  logic clk, reset, half_raw, one_raw, accept_en;
  logic half, one, reject, jam_half, jam_one;

  int n_checks = 0;
  int n_errors = 0;
  int n_half = 0, n_one = 0, n_rej = 0, n_both = 0;
  int h0, o0, r0;

  coin_pulse_gen dut (
    .clk       (clk),
    .reset     (reset),
    .half_raw  (half_raw),
    .one_raw   (one_raw),
    .accept_en (accept_en),
    .half      (half),
    .one       (one),
    .reject    (reject),
    .jam_half  (jam_half),
    .jam_one   (jam_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (half)        n_half++;
    if (one)         n_one++;
    if (reject)      n_rej++;
    if (half && one) n_both++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; half_raw = 1'b0; one_raw = 1'b0; accept_en = 1'b0;
    #100;
    check_eq("rst_half",     int'(half),     0);
    check_eq("rst_one",      int'(one),      0);
    check_eq("rst_reject",   int'(reject),   0);
    check_eq("rst_jam_half", int'(jam_half), 0);
    check_eq("rst_jam_one",  int'(jam_one),  0);
    reset = 1'b1;
    tick(2);
    accept_en = 1'b1;

    // Single half coin: pulse exactly 7 edges after the raw rise.
    h0 = n_half;
    half_raw = 1'b1;
    tick(6); check_eq("half_early", int'(half), 0);
    tick(1); check_eq("half_lat",   int'(half), 1);
    tick(13); half_raw = 1'b0; tick(15);
    check_eq("half_count", n_half - h0, 1);

    // Bounce on one: no pulse while toggling, one pulse 7 after final rise.
    o0 = n_one;
    for (int i = 0; i < 6; i++) begin
      one_raw = (i % 2 == 0);
      tick(1);
    end
    one_raw = 1'b1;
    tick(6); check_eq("bounce_early", int'(one), 0);
    check_eq("bounce_quiet", n_one - o0, 0);
    tick(1); check_eq("bounce_lat", int'(one), 1);
    tick(13); one_raw = 1'b0; tick(15);
    check_eq("bounce_count", n_one - o0, 1);

    // Simultaneous coins: half at t, one at t+3.
    half_raw = 1'b1; one_raw = 1'b1;
    tick(7);
    check_eq("sim_half_t", int'(half), 1);
    check_eq("sim_one_t",  int'(one),  0);
    tick(3);
    check_eq("sim_one_t3",  int'(one),  1);
    check_eq("sim_half_t3", int'(half), 0);
    tick(1); check_eq("sim_one_t4", int'(one), 0);
    tick(10); half_raw = 1'b0; one_raw = 1'b0; tick(15);

    // Reject while not accepting.
    accept_en = 1'b0;
    h0 = n_half; r0 = n_rej;
    half_raw = 1'b1;
    tick(6); check_eq("rej_pulse", int'(reject), 1);
    tick(1); check_eq("rej_end",   int'(reject), 0);
    tick(10); half_raw = 1'b0; tick(15);
    check_eq("rej_count", n_rej - r0, 1);
    check_eq("rej_nohalf", n_half - h0, 0);

    // Both channels rejected together: single reject pulse.
    r0 = n_rej; o0 = n_one;
    half_raw = 1'b1; one_raw = 1'b1;
    tick(20); half_raw = 1'b0; one_raw = 1'b0; tick(15);
    check_eq("rej_both_count", n_rej - r0, 1);
    check_eq("rej_both_none",  n_one - o0, 0);
    accept_en = 1'b1;

    // Jam on one: pulse, then jam 69 edges after the rise.
    one_raw = 1'b1;
    tick(7);  check_eq("jam_coin", int'(one), 1);
    tick(61); check_eq("jam_before", int'(jam_one), 0);
    tick(1);  check_eq("jam_set",    int'(jam_one), 1);
    check_eq("jam_half_clear", int'(jam_half), 0);
    tick(31); one_raw = 1'b0;
    tick(5);  check_eq("jam_hold",  int'(jam_one), 1);
    tick(1);  check_eq("jam_clear", int'(jam_one), 0);
    tick(10);
    one_raw = 1'b1;
    tick(7);  check_eq("jam_recover", int'(one), 1);
    tick(13); one_raw = 1'b0; tick(15);

    // accept_en drops after the coin was accepted: still emitted.
    h0 = n_half;
    half_raw = 1'b1;
    tick(6); accept_en = 1'b0;
    tick(1); check_eq("late_accept", int'(half), 1);
    tick(13); half_raw = 1'b0; tick(15);
    check_eq("late_accept_count", n_half - h0, 1);
    accept_en = 1'b1;

    // Reset mid-operation discards a pending coin.
    h0 = n_half;
    half_raw = 1'b1;
    tick(6);
    reset = 1'b0; half_raw = 1'b0;
    tick(3); check_eq("midrst_half", int'(half), 0);
    reset = 1'b1;
    tick(20);
    check_eq("midrst_count", n_half - h0, 0);

    // Five half coins then three one coins.
    h0 = n_half; o0 = n_one;
    for (int i = 0; i < 5; i++) begin
      half_raw = 1'b1; tick(5); half_raw = 1'b0; tick(10);
    end
    for (int i = 0; i < 3; i++) begin
      one_raw = 1'b1; tick(5); one_raw = 1'b0; tick(10);
    end
    tick(15);
    check_eq("seq_half", n_half - h0, 5);
    check_eq("seq_one",  n_one - o0,  3);
    check_eq("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
